fila_param: RTL
===============

# fila_param

Parametrised circular-buffer queue: the next-generation successor to the team's fixed 8×8 shift-register queue. It runs on the 10 kHz system clock between the input capture logic and the display/transmit path. Write and read are each single-cycle, and both may occur on the same edge. The block reports occupancy, full/empty/almost-full status, and sticky overflow/underflow errors. A synchronous flush empties the queue without a reset.

## Interface
Parameters:
- WIDTH, 8, data word width in bits (≥1)
- DEPTH, 8, number of entries (≥2, need not be a power of two)
- AF_LEVEL, DEPTH-1, occupancy at or above which almost_full is asserted (1..DEPTH)
- CW, $clog2(DEPTH+1), width of occupancy count (derived, not overridden)

Ports:
- clk_10KHz  in  1  system clock; all state changes on rising edge
- reset  in  1  asynchronous, active-low reset; one clock domain only
- data_in  in  WIDTH  word to enqueue
- enqueue_in  in  1  write request, sampled each rising edge
- dequeue_in  in  1  read request, sampled each rising edge
- flush_in  in  1  synchronous clear of queue contents
- clear_err_in  in  1  synchronous clear of sticky error flags
- data_out  out  WIDTH  last dequeued word (registered, holds until next dequeue)
- valid_out  out  1  one-cycle pulse: data_out updated on this edge
- len_out  out  CW  current occupancy, 0..DEPTH
- full_out  out  1  len_out == DEPTH
- empty_out  out  1  len_out == 0
- almost_full_out  out  1  len_out ≥ AF_LEVEL
- overflow_out  out  1  sticky: enqueue refused while full
- underflow_out  out  1  sticky: dequeue refused while empty

## Operation
- Storage: DEPTH×WIDTH array, write pointer wr_ptr, read pointer rd_ptr, count cnt (CW bits). Pointers wrap from DEPTH-1 to 0 by explicit compare, not by bit truncation.
- Reset (reset=0, asynchronous): wr_ptr=rd_ptr=cnt=0, data_out=0, valid_out=0, overflow_out=underflow_out=0. Outputs derived from cnt therefore read len_out=0, empty_out=1, full_out=0, almost_full_out=(AF_LEVEL==0 → never; AF_LEVEL≥1 → 0). Array contents need not be cleared.
- Accept rules evaluated per edge on pre-edge cnt:
  - do_deq = dequeue_in && cnt>0
  - do_enq = enqueue_in && (cnt<DEPTH || do_deq)
- do_enq: mem[wr_ptr]<=data_in; wr_ptr advances.
- do_deq: data_out<=mem[rd_ptr]; rd_ptr advances; valid_out<=1. Otherwise valid_out<=0 and data_out holds.
- Count: cnt <= cnt + do_enq − do_deq. A simultaneous accepted pair leaves cnt unchanged.
- There is no fall-through: enqueue and dequeue on an empty queue means the dequeue is refused and the enqueue is accepted.
- Errors: underflow_out<=1 if dequeue_in && cnt==0. overflow_out<=1 if enqueue_in && !do_enq. Both stay set until clear_err_in or reset. If clear_err_in coincides with a new error event, the flag is set (set wins).
- flush_in (highest priority below reset): wr_ptr=rd_ptr=cnt=0, valid_out<=0. enqueue_in and dequeue_in on that edge are ignored, and no error flags are raised by them. data_out holds its value. Error flags are unaffected unless clear_err_in is also high.
- Status outputs are combinational decodes of the registered cnt: no extra latency, no glitch-sensitive logic.

## Timing
- Enqueue latency: a word accepted at edge N is readable by a dequeue at edge N+1. It appears on data_out after edge N+1 when the queue was empty.
- Dequeue latency: data_out and valid_out are valid after the accepting edge, and valid_out is high for exactly one cycle per accepted dequeue. Back-to-back dequeues give one word per cycle.
- len_out and flags reflect the accepted operations of the previous edge, with 1-cycle latency.
- Sustained throughput: 1 enqueue + 1 dequeue per cycle at any occupancy 1..DEPTH. At full, a simultaneous enqueue and dequeue are both accepted.
- Reset asserted mid-operation aborts immediately (asynchronous). The first edge after release performs normal sampling.

## Test plan
DEPTH=4, WIDTH=8, AF_LEVEL=3 unless noted.
- Reset, then enqueue 0x11,0x22,0x33,0x44 on four edges → len_out 1,2,3,4; almost_full_out rises with len=3; full_out=1 at len=4; overflow_out=0.
- Full queue, enqueue 0x55 alone → overflow_out=1, len_out stays 4. Then dequeue ×4 → data_out 0x11,0x22,0x33,0x44 with valid_out pulse each cycle; empty_out=1; 0x55 never appears.
- Full queue, enqueue 0x66 + dequeue on the same edge → data_out=0x11, len_out=4, overflow_out=0. Wrap check: 10 alternating enqueue/dequeue cycles return words in exact FIFO order across the pointer wrap.
- Empty queue, enqueue 0x77 + dequeue on the same edge → underflow_out=1, valid_out=0, len_out=1. Next edge dequeue → data_out=0x77. clear_err_in → underflow_out=0.
- len=3, assert flush_in with enqueue_in=1 → len_out=0, empty_out=1, no error flag. A subsequent enqueue of 0x99 then dequeue returns 0x99.
- Drive reset low mid-burst (len=2, valid_out high) → all outputs at reset values immediately, without waiting for a clock edge. Enqueue after release works normally.

Source files
------------

// File: rtl/fila_param.sv
// fila_param: parametrised circular-buffer queue with occupancy,
// almost-full status, sticky overflow/underflow flags and synchronous flush.
module fila_param #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = DEPTH - 1,
    parameter int CW       = $clog2(DEPTH + 1)
) (
    input  logic             clk_10KHz,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             enqueue_in,
    input  logic             dequeue_in,
    input  logic             flush_in,
    input  logic             clear_err_in,
    output logic [WIDTH-1:0] data_out,
    output logic             valid_out,
    output logic [CW-1:0]    len_out,
    output logic             full_out,
    output logic             empty_out,
    output logic             almost_full_out,
    output logic             overflow_out,
    output logic             underflow_out
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_CNT   = CW'(AF_LEVEL);

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             valid_q, valid_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    logic do_enq, do_deq, mem_we;
    logic ovf_ev, unf_ev;

    always_comb begin
        do_deq   = dequeue_in && (cnt_q != '0);
        do_enq   = enqueue_in && ((cnt_q < FULL_CNT) || do_deq);
        unf_ev   = dequeue_in && (cnt_q == '0);
        ovf_ev   = enqueue_in && !do_enq;
        mem_we   = 1'b0;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        dout_d   = dout_q;
        valid_d  = 1'b0;
        ovf_d    = clear_err_in ? 1'b0 : ovf_q;
        unf_d    = clear_err_in ? 1'b0 : unf_q;
        if (flush_in) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (do_enq) begin
                mem_we   = 1'b1;
                wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
            end
            if (do_deq) begin
                dout_d   = mem_q[rd_ptr_q];
                valid_d  = 1'b1;
                rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
            end
            if (do_enq && !do_deq)
                cnt_d = cnt_q + CW'(1);
            else if (do_deq && !do_enq)
                cnt_d = cnt_q - CW'(1);
            // a new error event wins over a coincident clear
            if (ovf_ev) ovf_d = 1'b1;
            if (unf_ev) unf_d = 1'b1;
        end
    end

    always_ff @(posedge clk_10KHz or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            dout_q   <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            dout_q   <= dout_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    always_ff @(posedge clk_10KHz) begin
        if (mem_we) mem_q[wr_ptr_q] <= data_in;
    end

    assign data_out        = dout_q;
    assign valid_out       = valid_q;
    assign len_out         = cnt_q;
    assign full_out        = (cnt_q == FULL_CNT);
    assign empty_out       = (cnt_q == '0);
    assign almost_full_out = (AF_LEVEL >= 1) && (cnt_q >= AF_CNT);
    assign overflow_out    = ovf_q;
    assign underflow_out   = unf_q;
endmodule
